// File: rtl/exmem_skid_stage_reg_if.sv
// Handshake and payload bundle between the ALU stage, the EX/MEM skid register and the memory stage.
// The stage uses the slave modport; the upstream/downstream driver uses the master modport.
interface exmem_skid_stage_reg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wb_en_in;
  logic                  mem_r_en_in;
  logic                  mem_w_en_in;
  logic [DATA_WIDTH-1:0] alu_result_in;
  logic [DATA_WIDTH-1:0] val_rm_in;
  logic [DEST_WIDTH-1:0] dest_in;
  logic                  out_valid;
  logic                  out_ready;
  logic                  wb_en;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] val_rm;
  logic [DEST_WIDTH-1:0] dest;
  logic [1:0]            occupancy;
  logic [CNT_WIDTH-1:0]  stall_count;

  modport slave (
    input  flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in,
           alu_result_in, val_rm_in, dest_in, out_ready,
    output in_ready, out_valid, wb_en, mem_r_en, mem_w_en,
           alu_result, val_rm, dest, occupancy, stall_count
  );

  modport master (
    output flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in,
           alu_result_in, val_rm_in, dest_in, out_ready,
    input  in_ready, out_valid, wb_en, mem_r_en, mem_w_en,
           alu_result, val_rm, dest, occupancy, stall_count
  );
endinterface

// File: rtl/exmem_skid_stage_reg.sv
// EX/MEM pipeline register with a two-entry skid buffer, flush squash and a saturating stall counter.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; valid never waits on ready.
module exmem_skid_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  exmem_skid_stage_reg_if.slave         bus
);
  // Payload packing, low to high: alu_result, val_rm, dest, mem_w_en, mem_r_en, wb_en.
  localparam int PW = 3 + 2 * DATA_WIDTH + DEST_WIDTH;

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        main_q, skid_q, in_payload;
  logic [CNT_WIDTH-1:0] stall_q;
  logic                 in_ready, out_valid, in_fire, out_fire;
  logic                 load_main_in, load_main_skid, load_skid;

  assign in_payload = {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in,
                       bus.dest_in, bus.val_rm_in, bus.alu_result_in};

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = bus.in_valid & in_ready & ~bus.flush;
  assign out_fire  = out_valid & bus.out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = BUSY;
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          load_main_skid = 1'b1;
          state_nxt      = BUSY;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_q <= in_payload;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_payload;
      end
      if (out_valid && !bus.out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
        stall_q <= stall_q + CNT_WIDTH'(1);
      end
    end
  end

  // Stale payload may sit in main_q when empty; only the write-enables need gating.
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.wb_en       = out_valid & main_q[PW-1];
  assign bus.mem_r_en    = out_valid & main_q[PW-2];
  assign bus.mem_w_en    = out_valid & main_q[PW-3];
  assign bus.dest        = main_q[2*DATA_WIDTH +: DEST_WIDTH];
  assign bus.val_rm      = main_q[DATA_WIDTH +: DATA_WIDTH];
  assign bus.alu_result  = main_q[0 +: DATA_WIDTH];
  assign bus.occupancy   = state;
  assign bus.stall_count = stall_q;
endmodule

// File: doc/exmem_skid_stage_reg.md
# exmem_skid_stage_reg

Parametrised execution-to-memory pipeline stage register with a valid/ready handshake on both sides and a two-entry skid buffer. It sits between the ALU stage and the data-memory stage and carries the writeback/memory control bits, the ALU result, the store operand (Rm value) and the destination register index. It supports back-pressure from the memory stage, a synchronous flush for branch/exception squash, and a saturating stall counter for performance monitoring.

## Interface
- DATA_WIDTH, 32: width of the ALU result and the Rm value.
- DEST_WIDTH, 4: width of the destination register index.
- CNT_WIDTH, 16: width of the stall counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  squashes every held entry and any incoming entry this cycle.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry; registered, not combinational from out_ready.
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits.
- alu_result_in, val_rm_in  in  DATA_WIDTH each  payload.
- dest_in  in  DEST_WIDTH  destination register index.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage accepts the head.
- wb_en, mem_r_en, mem_w_en  out  1 each  head control bits; forced to 0 when out_valid=0.
- alu_result, val_rm  out  DATA_WIDTH each  head payload.
- dest  out  DEST_WIDTH  head destination.
- occupancy  out  2  number of held entries (0..2).
- stall_count  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0.

## Operation
- in_fire = in_valid & in_ready & !flush. out_fire = out_valid & out_ready.
- Storage: main entry (head) and skid entry, each holding the full payload.
- States: EMPTY (occupancy 0), BUSY (1), FULL (2). in_ready = (state != FULL). out_valid = (state != EMPTY).
- State transitions:
  - EMPTY: in_fire loads main, then BUSY.
  - BUSY with in_fire and out_fire: main reloads from the inputs; stays BUSY.
  - BUSY with in_fire only: skid loads from the inputs, then FULL.
  - BUSY with out_fire only: goes to EMPTY.
  - FULL: in_fire cannot occur. out_fire copies skid into main, then BUSY.
- Ordering is strict FIFO. The skid entry is never presented before the main entry.
- Flush has priority over all else. The next state is EMPTY, and the current input is dropped. A head with out_fire in the flush cycle counts as delivered.
- Payload registers of empty entries hold stale values. Their control bits are gated, so stale data never produces a write.
- stall_count increments on every cycle with out_valid & !out_ready, including the flush cycle. It saturates at 2^CNT_WIDTH-1 and is cleared only by rst.
- Reset: state EMPTY, both entries' control bits 0, payloads 0, stall_count 0.

## Timing
- Latency is 1 cycle: an entry accepted at edge N appears on the outputs after edge N.
- Throughput is 1 entry per cycle while out_ready=1.
- out_ready low at edge N: in_ready stays 1 while BUSY, so one more entry is absorbed into skid. in_ready drops to 0 after that edge.
- in_ready returns to 1 the cycle after the out_fire that drains FULL to BUSY.
- Output values after reset (rst high at an edge):
  - out_valid=0 and in_ready=1.
  - wb_en, mem_r_en and mem_w_en are 0.
  - alu_result, val_rm and dest are 0.
  - occupancy=0 and stall_count=0.
- rst mid-operation discards all entries and wins over flush and in_valid.
- Outputs depend only on registers. No combinational path runs from out_ready to in_ready.

## Test plan
- **Reset:** drive rst for 2 cycles with in_valid=1. Required: out_valid=0, in_ready=1, occupancy=0, stall_count=0, all outputs 0.
- **Streaming:** hold out_ready=1 and send 4 entries with alu_result 0x10,0x20,0x30,0x40 and dest 1..4 on consecutive cycles. Required: each appears 1 cycle later, in order, with occupancy=1 throughout.
- **Back-pressure:** send A=0xA, B=0xB, C=0xC back-to-back while out_ready=0 from the cycle A appears.
  - Required: B is absorbed, occupancy=2, in_ready=0, and C is held upstream.
  - Release out_ready: outputs A, B, C in order with none lost, and stall_count equals the stalled cycle count.
- **Flush:** flush while FULL with in_valid=1 and out_ready=0. Required next cycle: occupancy=0, out_valid=0, and wb_en, mem_r_en and mem_w_en are 0. The incoming entry never appears.
- **Saturation:** with CNT_WIDTH=4, hold out_valid=1 and out_ready=0 for 20 cycles. Required: stall_count stops at 15.
- **Simultaneous fire:** in BUSY, assert in_valid and out_ready together for 3 cycles. Required: occupancy stays 1, and each new entry replaces the head one cycle later.
